// File: rtl/fifo_pkg.sv
// -----------------------------------------------------------------------------
// fifo_pkg
// Shared definitions for the FIFO reader:
//   WIDTH_DEFAULT : default data width of the FIFO read port / output stream
//   buf_state_e   : output-buffer occupancy state (B0 = empty, B1 = one, B2 = full)
//   rd_state_t    : FSM state = occupancy plus the one-cycle read-in-flight flag
//   occ_count     : occupancy state -> numeric count
//   occ_state     : numeric count -> occupancy state
// -----------------------------------------------------------------------------
package fifo_pkg;

    localparam int WIDTH_DEFAULT = 32;

    typedef enum logic [1:0] {
        B0 = 2'd0,
        B1 = 2'd1,
        B2 = 2'd2
    } buf_state_e;

    typedef struct packed {
        buf_state_e occ;
        logic       inflight;
    } rd_state_t;

    function automatic logic [1:0] occ_count(input buf_state_e s);
        return logic'(s == B2) ? 2'd2 : (s == B1) ? 2'd1 : 2'd0;
    endfunction

    // Counts above 2 cannot occur (the read throttle keeps occ + in-flight
    // at or below 2); they saturate to B2 so the mapping stays total.
    function automatic buf_state_e occ_state(input logic [2:0] n);
        case (n)
            3'd0:    return B0;
            3'd1:    return B1;
            default: return B2;
        endcase
    endfunction

endpackage

// File: rtl/fifo_reader_skid.sv
// -----------------------------------------------------------------------------
// fifo_reader_skid
// Two-entry in-order output buffer. Occupancy is owned by the FSM in
// fifo_reader and passed in; this block only moves data between its two
// registers so that the head word is always in entry 0.
//   Clk        : clock, rising edge
//   Rst        : asynchronous active-low reset
//   push       : write push_data at the tail this cycle
//   pop        : head word is consumed this cycle
//   occ        : current occupancy (B0/B1/B2) from the FSM
//   push_data  : word to append
//   head_data  : head entry (the downstream data word)
// -----------------------------------------------------------------------------
module fifo_reader_skid
    import fifo_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             push,
    input  logic             pop,
    input  buf_state_e       occ,
    input  logic [WIDTH-1:0] push_data,
    output logic [WIDTH-1:0] head_data
);

    logic [WIDTH-1:0] entry0;
    logic [WIDTH-1:0] entry1;

    // NOTE: the buffer registers are reset because the head entry drives the
    // output port directly and must read as zero while in reset; they use
    // non-blocking assignments like every other clocked register.
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            entry0 <= '0;
            entry1 <= '0;
        end else begin
            case (occ)
                B0: begin
                    if (push) entry0 <= push_data;
                end
                B1: begin
                    // Push with pop: the new word becomes the head directly.
                    if (push && pop) entry0 <= push_data;
                    else if (push)   entry1 <= push_data;
                end
                B2: begin
                    if (pop) begin
                        entry0 <= entry1;
                        if (push) entry1 <= push_data;
                    end
                end
                default: begin
                    entry0 <= entry0;
                end
            endcase
        end
    end

    assign head_data = entry0;

endmodule

// File: rtl/fifo_reader.sv
// -----------------------------------------------------------------------------
// fifo_reader
// Pulls words out of a synchronous-read FIFO (data valid the cycle after the
// read strobe) and presents them as a valid/ready stream with full throughput
// and two cycles of read-to-valid latency.
//   Clk        : clock, rising edge
//   Rst        : asynchronous active-low reset
//   EN         : enable; when low no new FIFO reads are issued
//   EMPTY      : FIFO empty flag
//   fifoData   : FIFO read data, valid the cycle after an accepted RD
//   RD         : FIFO read strobe (combinational)
//   dataOut    : downstream data word (head of the output buffer)
//   VALID      : dataOut holds a word
//   READY      : downstream accepts; transfer on VALID && READY
//   wordCount  : 16-bit wrapping count of completed transfers
//                (present only when FIFO_READER_COUNT_EN is defined)
// -----------------------------------------------------------------------------
module fifo_reader
    import fifo_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             EN,
    input  logic             EMPTY,
    input  logic [WIDTH-1:0] fifoData,
    output logic             RD,
    output logic [WIDTH-1:0] dataOut,
    output logic             VALID,
    input  logic             READY
`ifdef FIFO_READER_COUNT_EN
    ,
    output logic [15:0]      wordCount
`endif
);

    rd_state_t  state;
    rd_state_t  state_next;
    logic       pop;
    logic [2:0] pending;

    assign VALID = (state.occ != B0);
    assign pop   = VALID && READY;

    // NOTE: every output of this block gets a value before any branch so no
    // latch is inferred.
    always_comb begin
        state_next = '0;
        // Words that will be held after this edge: buffered + arriving - leaving.
        pending = {1'b0, occ_count(state.occ)} + {2'b00, state.inflight}
                  - {2'b00, pop};
        // A read is only issued if its word is guaranteed a slot, which keeps
        // occ + inflight <= 2 and makes buffer overflow impossible. Rst gates
        // the strobe so the FIFO is never popped while this block is in reset.
        RD = Rst && EN && !EMPTY && (pending < 3'd2);
        state_next.occ      = occ_state(pending);
        state_next.inflight = RD && !EMPTY;
    end

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state <= '{occ: B0, inflight: 1'b0};
        end else begin
            state <= state_next;
        end
    end

    fifo_reader_skid #(
        .WIDTH(WIDTH)
    ) u_skid (
        .Clk       (Clk),
        .Rst       (Rst),
        .push      (state.inflight),
        .pop       (pop),
        .occ       (state.occ),
        .push_data (fifoData),
        .head_data (dataOut)
    );

    overflow_a: assert property (@(posedge Clk) disable iff (!Rst)
        !(state.inflight && state.occ == B2 && !pop));

`ifdef FIFO_READER_COUNT_EN
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            wordCount <= 16'd0;
        end else if (pop) begin
            wordCount <= wordCount + 16'd1;
        end
    end
`else
    // No transfer counter in this build.
`endif

endmodule

// File: doc/fifo_reader.md
FIFO_READER -- requirements
Module: fifo_reader

Interface
REQ-001 Parameter WIDTH, default 32: data width of the FIFO read port and the downstream stream.
REQ-002 Clk  in  1  single clock; all state updates on the rising edge.
REQ-003 Rst  in  1  reset, asynchronous, active-low.
REQ-004 EN  in  1  enable; when low, no new FIFO reads are issued.
REQ-005 EMPTY  in  1  FIFO empty flag.
REQ-006 fifoData  in  WIDTH  FIFO read data; valid in the cycle after RD is high while EMPTY is low.
REQ-007 RD  out  1  FIFO read strobe.
REQ-008 dataOut  out  WIDTH  downstream data word.
REQ-009 VALID  out  1  dataOut holds a word.
REQ-010 READY  in  1  downstream accepts; a transfer occurs in any cycle with VALID && READY.

Function
REQ-011 Hold an internal 2-entry in-order output buffer, occupancy occ in {0,1,2}; dataOut and VALID reflect the head entry.
REQ-012 FSM states: B0 (occ 0), B1 (occ 1), B2 (occ 2); each state carries a 1-bit INFLIGHT flag, registered as RD && !EMPTY.
REQ-013 RD = EN && !EMPTY && (occ + INFLIGHT - pop) < 2, where pop = VALID && READY; RD is combinational from these terms.
REQ-014 When INFLIGHT is 1, capture fifoData into the buffer tail at the end of that cycle.
REQ-015 Latency: RD high in cycle t gives VALID high with that word in cycle t+2.
REQ-016 Throughput: with READY held high and the FIFO non-empty, one word per cycle in steady state, with no bubbles.
REQ-017 Capture and pop in the same cycle leave occ unchanged, and order is preserved.
REQ-018 With VALID high and READY low, dataOut and VALID hold stable until the transfer completes.
REQ-019 Buffer never overflows; a capture into a full buffer is unreachable by construction, and an assertion flags it.
REQ-020 EN falling: no new RD from that cycle; an in-flight word is still captured; buffered words still drain normally.
REQ-021 EMPTY rising mid-stream: RD deasserts in the same cycle; buffered words continue to drain.
REQ-022 A registered EMPTY toggle is not sampled as a read; RD is never high while EMPTY is high.

Reset
REQ-023 Rst low: occ=0, INFLIGHT=0, VALID=0, dataOut=0; RD low while Rst is low.
REQ-024 Reset mid-operation discards buffered and in-flight words; a word already popped from the FIFO is lost, and the FIFO is reset alongside.
REQ-025 First RD may be issued in the first cycle after Rst goes high.

Configuration
REQ-026 Macro FIFO_READER_COUNT_EN, when defined, adds output wordCount (16 bits): the count of completed transfers.
REQ-027 wordCount increments on each VALID && READY, wraps 16'hFFFF to 0, and resets to 0.
REQ-028 Without FIFO_READER_COUNT_EN, the wordCount port and counter are absent, with identical other behaviour.

Structure
REQ-029 Shared package fifo_pkg holds the WIDTH default constant and the buffer-state enum (B0, B1, B2).
REQ-030 The 2-entry buffer is sub-module fifo_reader_skid (push, pop, head data, occ); RD logic and the FSM stay in fifo_reader.

Verification
REQ-031 Bench pairs fifo_reader with a FIFObuffer model: write 0..4, READY=1 -> dataOut 0,1,2,3,4 on five consecutive VALID cycles, first VALID 2 cycles after first RD.
REQ-032 Backpressure: FIFO holds 0..4, READY=0 -> exactly 2 RD pulses, VALID=1 with dataOut=0 stable; READY=1 -> 0..4 delivered in order, none lost.
REQ-033 Empty: FIFO holds 1 word (32'hA5) -> one RD, one transfer of A5, then RD=0 and VALID=0 while EMPTY=1.
REQ-034 EN=0 after the second RD -> words 0 and 1 delivered, no further RD; EN=1 -> resumes with word 2.
REQ-035 Rst low with occ=2 and INFLIGHT=1 -> VALID=0, dataOut=0, RD=0 immediately; no stale word appears after release.
REQ-036 With FIFO_READER_COUNT_EN: 65537 transfers -> wordCount=1; without the macro, the build has no wordCount port.
